// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-expansion state encoding and GF(2^8) helpers
package aes_pkg;

  localparam int         KEY_NUM_COLS   = 44;
  localparam int         KEY_ROW_STRIDE = 120;
  localparam int         KEY_ADDR_W     = 9;
  localparam logic [7:0] RCON_INIT      = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_EXPAND = 4'b0100,
    ST_DONE   = 4'b1000
  } kx_state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box (GF inverse followed by affine map)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128, which also maps zero to zero.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 1; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign out_o = sbox_fwd(in_i);

endmodule

// File: rtl/aes_key_expand_128.sv
// rtl/aes_key_expand_128.sv - AES-128 key schedule writer into the row-major round-key byte RAM
module aes_key_expand_128
  import aes_pkg::*;
#(
  parameter int NUM_COLS   = KEY_NUM_COLS,
  parameter int ROW_STRIDE = KEY_ROW_STRIDE,
  parameter int ADDR_W     = KEY_ADDR_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [127:0]      cipher_key,
  output logic [ADDR_W-1:0] word_address0,
  output logic [ADDR_W-1:0] word_address1,
  output logic [ADDR_W-1:0] word_address2,
  output logic [ADDR_W-1:0] word_address3,
  output logic              word_ce0,
  output logic              word_ce1,
  output logic              word_ce2,
  output logic              word_ce3,
  output logic              word_we0,
  output logic              word_we1,
  output logic              word_we2,
  output logic              word_we3,
  output logic [7:0]        word_d0,
  output logic [7:0]        word_d1,
  output logic [7:0]        word_d2,
  output logic [7:0]        word_d3
);

  localparam int COL_W = $clog2(NUM_COLS);

  kx_state_e        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [127:0]     win_q, win_d;
  logic [7:0]       rcon_q, rcon_d;

  logic [31:0] rot_w, sub_w, temp_w, new_w, load_col, wr_col;
  logic        busy;

  // Window holds w[col-4] in [127:96] down to the newest column w[col-1] in [31:0].
  assign rot_w = {win_q[23:0], win_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_w[31-8*i -: 8]),
      .out_o (sub_w[31-8*i -: 8])
    );
  end

  assign temp_w = (col_q[1:0] == 2'd0) ? (sub_w ^ {rcon_q, 24'h0}) : win_q[31:0];
  assign new_w  = win_q[127:96] ^ temp_w;

  always_comb begin
    case (col_q[1:0])
      2'd0:    load_col = win_q[127:96];
      2'd1:    load_col = win_q[95:64];
      2'd2:    load_col = win_q[63:32];
      default: load_col = win_q[31:0];
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      win_q   <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      win_q   <= win_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    win_d   = win_q;
    rcon_d  = rcon_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          win_d   = cipher_key;
          col_d   = '0;
          rcon_d  = RCON_INIT;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(3)) state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        win_d = {win_q[95:0], new_w};
        col_d = col_q + COL_W'(1);
        if (col_q[1:0] == 2'd0) rcon_d = xtime(rcon_q);
        if (col_q == COL_W'(NUM_COLS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
  assign wr_col   = (state_q == ST_EXPAND) ? new_w : load_col;
  assign ap_idle  = (state_q == ST_IDLE) && !ap_start;
  assign ap_done  = (state_q == ST_DONE);
  assign ap_ready = (state_q == ST_DONE);

  logic [ADDR_W-1:0] addr [4];
  logic [7:0]        data [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      addr[r] = '0;
      data[r] = '0;
      if (busy) begin
        addr[r] = ADDR_W'(col_q) + ADDR_W'(r * ROW_STRIDE);
        data[r] = wr_col[31-8*r -: 8];
      end
    end
  end

  assign word_address0 = addr[0];
  assign word_address1 = addr[1];
  assign word_address2 = addr[2];
  assign word_address3 = addr[3];
  assign word_d0       = data[0];
  assign word_d1       = data[1];
  assign word_d2       = data[2];
  assign word_d3       = data[3];
  assign word_ce0      = busy;
  assign word_ce1      = busy;
  assign word_ce2      = busy;
  assign word_ce3      = busy;
  assign word_we0      = busy;
  assign word_we1      = busy;
  assign word_we2      = busy;
  assign word_we3      = busy;

endmodule
